fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the pipelined core. It sits directly upstream of the hazard unit's stall_if/flush_id outputs and consumes them.
- Owns the fetch PC and drives a single-outstanding request/ack port to instruction memory.
- Buffers returned instructions in a small FIFO and drives the IF/ID pipeline register (inst_id, pc_id, valid_id) into decode.
- Handles branch/trap redirects, including ones that arrive while a memory request is in flight.

Parameters:
- DATA_SIZE, 64, width of PC and addresses.
- RESET_PC, 0, first fetch address after reset.
- BUFFER_DEPTH, 2, instruction FIFO entries (power of two, >=2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_if  in  1  from hazard unit; freezes the IF/ID register.
- flush_id  in  1  from hazard unit; loads a bubble into IF/ID.
- redirect_en  in  1  taken branch/jump/trap.
- redirect_pc  in  DATA_SIZE  new fetch target.
- inst_mem_rd_en  out  1  memory request.
- inst_mem_addr  out  DATA_SIZE  request address, always 4-aligned.
- inst_mem_ack  in  1  single-cycle response strobe.
- inst_mem_rd_dat  in  32  instruction, valid with ack.
- inst_id  out  32  IF/ID instruction.
- pc_id  out  DATA_SIZE  IF/ID PC.
- valid_id  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE.
  - inst_mem_rd_en=0; inst_mem_addr=RESET_PC.
  - inst_id=32'h00000013 (NOP); pc_id=0; valid_id=0.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE→REQ when fifo_count<BUFFER_DEPTH and !redirect_en. The first request is raised in the first cycle after reset deasserts.
  - REQ: rd_en=1, addr=fetch_pc, both held stable until ack.
    - On ack without redirect: push {fetch_pc, rd_dat}; fetch_pc+=4 (wraps modulo 2^DATA_SIZE).
    - After the ack, go to REQ if fifo_count after push/pop <BUFFER_DEPTH, else IDLE. Back-to-back requests are allowed (rd_en stays high with the new addr next cycle).
  - Redirect in REQ without ack in the same cycle → DRAIN. DRAIN keeps rd_en=1 with the old addr until ack, discards that data, then goes to REQ/IDLE at the new PC.
  - Redirect in the same cycle as ack: data discarded; next request goes to the new PC.
  - Redirect in DRAIN: updates fetch_pc only; remains in DRAIN.
- Redirect (any state):
  - FIFO cleared in the same cycle.
  - fetch_pc := {redirect_pc[DATA_SIZE-1:2], 2'b00}.
  - A simultaneous push is dropped.
- FIFO:
  - Push and pop in the same cycle is legal at any occupancy, including full; count is unchanged.
  - Never push when full: guaranteed by the issue condition; a bench assertion checks it.
- IF/ID register update, priority order:
  1. flush_id or redirect_en → valid_id=0, inst_id=NOP, pc_id unchanged. Applies even if stall_if=1.
  2. stall_if → hold all of inst_id/pc_id/valid_id; no pop.
  3. FIFO non-empty → pop head into inst_id/pc_id; valid_id=1.
  4. Else → valid_id=0, inst_id=NOP.
- Latency: with ack in the cycle after rd_en rises, instruction at PC X appears on IF/ID 2 cycles after its request is issued. There is no FIFO bypass.
- stall_if does not stop fetching; the FIFO keeps filling until full.
- inst_mem_addr bits [1:0] are always 0.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- When defined, two extra outputs are added:
  - fetch_stall_cycles (64, out): counts cycles with stall_if=1.
  - fetch_starve_cycles (64, out): counts cycles where stall_if=0, flush_id=0 and the FIFO is empty.
  - Both reset to 0 and saturate at all-ones.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: release reset, memory acks 1 cycle after each request with data=addr^32'hA5A5A5A5 → addr 0x0,0x4,0x8… issued back-to-back; IF/ID shows pc_id 0x0 then 0x4… with valid_id=1 and matching inst_id.
- Stall: stall_if=1 for 4 cycles while pc_id=0x8 → outputs hold 0x8; FIFO fills to 2; rd_en drops to 0. After release, pc_id 0xC and 0x10 follow on consecutive cycles.
- Redirect while a request is in flight: redirect_en pulse with redirect_pc=0x100 while ack for 0x10 is delayed 3 cycles → rd_en stays on 0x10 until ack; that data is discarded; next addr=0x100; valid_id=0 until 0x100 arrives.
- Flush beats stall: flush_id=1 with stall_if=1 → next cycle valid_id=0, inst_id=0x00000013, pc_id unchanged.
- Misaligned redirect: redirect_pc=0x203, ack coincident with redirect → ack data dropped; next inst_mem_addr=0x200.
- Reset mid-request: assert reset in REQ with ack pending → outputs immediately at reset values; after release, the first addr is RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding request/ack memory port,
// buffers returned instructions and drives the IF/ID register. Optional FETCH_PERF_COUNTERS_EN adds stall/starve counters.
module fetch_stage #(
    parameter int                   DATA_SIZE    = 64,
    parameter logic [DATA_SIZE-1:0] RESET_PC     = '0,
    parameter int                   BUFFER_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall_if,
    input  logic                 flush_id,
    input  logic                 redirect_en,
    input  logic [DATA_SIZE-1:0] redirect_pc,
    output logic                 inst_mem_rd_en,
    output logic [DATA_SIZE-1:0] inst_mem_addr,
    input  logic                 inst_mem_ack,
    input  logic [31:0]          inst_mem_rd_dat,
    output logic [31:0]          inst_id,
    output logic [DATA_SIZE-1:0] pc_id,
    output logic                 valid_id
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [63:0]          fetch_stall_cycles,
    output logic [63:0]          fetch_starve_cycles
`endif
);

    localparam logic [31:0]          NOP       = 32'h0000_0013;
    localparam int                   PTR_W     = $clog2(BUFFER_DEPTH);
    localparam int                   CNT_W     = $clog2(BUFFER_DEPTH + 1);
    localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(BUFFER_DEPTH);
    localparam logic [DATA_SIZE-1:0] ALIGN_M   = ~DATA_SIZE'(3);
    localparam logic [DATA_SIZE-1:0] RESET_PCA = RESET_PC & ALIGN_M;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t               state, state_next;
    logic [DATA_SIZE-1:0] fetch_pc;
    logic [DATA_SIZE-1:0] drain_addr;
    logic [DATA_SIZE-1:0] fifo_pc   [BUFFER_DEPTH];
    logic [31:0]          fifo_inst [BUFFER_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_count, count_next;
    logic                 push, pop, fifo_empty;

    // Data returned for a request that was redirected away is never pushed.
    assign push       = (state == REQ) && inst_mem_ack && !redirect_en;
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !flush_id && !redirect_en && !stall_if && !fifo_empty;

    always_comb begin
        count_next = fifo_count;
        if (redirect_en)
            count_next = '0;
        else if (push && !pop)
            count_next = fifo_count + CNT_W'(1);
        else if (pop && !push)
            count_next = fifo_count - CNT_W'(1);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        inst_mem_rd_en = 1'b0;
        inst_mem_addr  = fetch_pc;
        case (state)
            IDLE: begin
                if (fifo_count < DEPTH_C && !redirect_en)
                    state_next = REQ;
            end
            REQ: begin
                inst_mem_rd_en = 1'b1;
                if (inst_mem_ack)
                    state_next = (count_next < DEPTH_C) ? REQ : IDLE;
                else if (redirect_en)
                    state_next = DRAIN;
            end
            DRAIN: begin
                inst_mem_rd_en = 1'b1;
                inst_mem_addr  = drain_addr;
                if (inst_mem_ack)
                    state_next = (count_next < DEPTH_C) ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PCA;
            drain_addr <= RESET_PCA;
        end else begin
            state <= state_next;
            // Remembers the in-flight address so a redirect can move fetch_pc while we drain.
            if (state != DRAIN)
                drain_addr <= fetch_pc;
            if (redirect_en)
                fetch_pc <= redirect_pc & ALIGN_M;
            else if (push)
                fetch_pc <= fetch_pc + DATA_SIZE'(4);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            fifo_count <= count_next;
            if (redirect_en) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: FIFO storage is not reset; fifo_count alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= fetch_pc;
            fifo_inst[wr_ptr] <= inst_mem_rd_dat;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_id  <= NOP;
            pc_id    <= '0;
            valid_id <= 1'b0;
        end else if (flush_id || redirect_en) begin
            inst_id  <= NOP;
            valid_id <= 1'b0;
        end else if (!stall_if) begin
            if (!fifo_empty) begin
                inst_id  <= fifo_inst[rd_ptr];
                pc_id    <= fifo_pc[rd_ptr];
                valid_id <= 1'b1;
            end else begin
                inst_id  <= NOP;
                valid_id <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_stall_cycles  <= '0;
            fetch_starve_cycles <= '0;
        end else begin
            if (stall_if && fetch_stall_cycles != '1)
                fetch_stall_cycles <= fetch_stall_cycles + 64'd1;
            if (!stall_if && !flush_id && fifo_empty && fetch_starve_cycles != '1)
                fetch_starve_cycles <= fetch_starve_cycles + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table for reset/stall, directed redirect/flush/reset sequences,
// then randomized traffic against a queue-based reference model of the fetch rules.
module tb_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] SALT  = 32'hA5A5_A5A5;

    logic        clock, reset, stall_if, flush_id, redirect_en;
    logic [63:0] redirect_pc, inst_mem_addr, pc_id;
    logic        inst_mem_rd_en, inst_mem_ack, valid_id;
    logic [31:0] inst_mem_rd_dat, inst_id;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [63:0] fetch_stall_cycles, fetch_starve_cycles;
`endif

    fetch_stage #(.DATA_SIZE(64), .RESET_PC(64'h0), .BUFFER_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall_if       (stall_if),
        .flush_id       (flush_id),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .inst_mem_rd_en (inst_mem_rd_en),
        .inst_mem_addr  (inst_mem_addr),
        .inst_mem_ack   (inst_mem_ack),
        .inst_mem_rd_dat(inst_mem_rd_dat),
        .inst_id        (inst_id),
        .pc_id          (pc_id),
        .valid_id       (valid_id)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetch_stall_cycles (fetch_stall_cycles),
        .fetch_starve_cycles(fetch_starve_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, actual, expected);
    endtask

    always @(posedge clock) begin
        if (!reset) begin
            assert (!(dut.push && int'(dut.fifo_count) == DEPTH))
            else begin
                n_checks++;
                $display("FAIL fifo_overflow: push at count %0d, want below %0d", dut.fifo_count, DEPTH);
            end
        end
    end

    // Reference model: the fetch buffer is a queue, the memory port is an outstanding/discard pair.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_fetch_pc, m_req_addr, m_pc;
    logic [31:0] m_inst;
    logic        m_valid, m_pending, m_discard;
    logic [63:0] m_stall_cnt, m_starve_cnt;

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc   = 64'h0;
        m_req_addr   = 64'h0;
        m_pc         = 64'h0;
        m_inst       = NOP;
        m_valid      = 1'b0;
        m_pending    = 1'b0;
        m_discard    = 1'b0;
        m_stall_cnt  = 64'h0;
        m_starve_cnt = 64'h0;
    endtask

    task automatic model_step();
        int   sz0;
        ent_t e;
        sz0 = m_q.size();
        if (stall_if) m_stall_cnt++;
        if (!stall_if && !flush_id && sz0 == 0) m_starve_cnt++;
        if (flush_id || redirect_en) begin
            m_valid = 1'b0;
            m_inst  = NOP;
        end else if (!stall_if) begin
            if (sz0 > 0) begin
                e       = m_q.pop_front();
                m_pc    = e.pc;
                m_inst  = e.inst;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_inst  = NOP;
            end
        end
        if (m_pending && inst_mem_ack && !m_discard && !redirect_en) begin
            m_q.push_back('{pc: m_req_addr, inst: inst_mem_rd_dat});
            m_fetch_pc = m_fetch_pc + 64'd4;
        end
        if (redirect_en) begin
            m_q.delete();
            m_fetch_pc = {redirect_pc[63:2], 2'b00};
        end
        if (m_pending && inst_mem_ack) begin
            m_pending = (m_q.size() < DEPTH);
            m_discard = 1'b0;
        end else if (m_pending) begin
            if (redirect_en) m_discard = 1'b1;
        end else begin
            m_pending = (sz0 < DEPTH) && !redirect_en;
        end
        if (!m_discard) m_req_addr = m_fetch_pc;
    endtask

    task automatic compare_model();
        check("rd_en", 64'(inst_mem_rd_en), 64'(m_pending));
        if (m_pending) begin
            check("addr", inst_mem_addr, m_req_addr);
            check("addr_align", 64'(inst_mem_addr[1:0]), 64'd0);
        end
        check("valid_id", 64'(valid_id), 64'(m_valid));
        check("inst_id", 64'(inst_id), 64'(m_inst));
        check("pc_id", pc_id, m_pc);
`ifdef FETCH_PERF_COUNTERS_EN
        check("stall_cycles", fetch_stall_cycles, m_stall_cnt);
        check("starve_cycles", fetch_starve_cycles, m_starve_cnt);
`endif
    endtask

    // Memory responder: acks a new request on the mem_wait-th edge after it is first seen.
    logic        mem_busy, mem_rand;
    int          mem_lat, mem_wait;
    logic [63:0] mem_addr;

    task automatic mem_step();
        if (reset) begin
            mem_busy     = 1'b0;
            inst_mem_ack = 1'b0;
            return;
        end
        if (inst_mem_ack) begin
            inst_mem_ack    = 1'b0;
            inst_mem_rd_dat = $urandom;
            mem_busy        = 1'b0;
        end
        if (inst_mem_rd_en && !mem_busy) begin
            mem_busy = 1'b1;
            mem_addr = inst_mem_addr;
            mem_wait = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
        end else if (mem_busy) begin
            check("req_hold_en", 64'(inst_mem_rd_en), 64'd1);
            check("req_hold_addr", inst_mem_addr, mem_addr);
        end
        if (mem_busy) begin
            mem_wait--;
            if (mem_wait <= 0) begin
                inst_mem_ack    = 1'b1;
                inst_mem_rd_dat = mem_addr[31:0] ^ SALT;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!reset) model_step();
        @(negedge clock);
        mem_step();
        compare_model();
    endtask

    typedef struct {
        logic        stall;
        logic        exp_rd;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] exp_inst;
    logic [63:0] saved_pc;
    int          n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Memory acks in the same cycle rd_en rises; stall covers edges 6..9 while pc_id=0x8.
        vecs[0]  = '{1'b0, 1'b1, 64'h00, 1'b0, 64'h00};
        vecs[1]  = '{1'b0, 1'b1, 64'h04, 1'b0, 64'h00};
        vecs[2]  = '{1'b0, 1'b1, 64'h08, 1'b1, 64'h00};
        vecs[3]  = '{1'b0, 1'b1, 64'h0C, 1'b1, 64'h04};
        vecs[4]  = '{1'b0, 1'b1, 64'h10, 1'b1, 64'h08};
        vecs[5]  = '{1'b1, 1'b0, 64'h00, 1'b1, 64'h08};
        vecs[6]  = '{1'b1, 1'b0, 64'h00, 1'b1, 64'h08};
        vecs[7]  = '{1'b1, 1'b0, 64'h00, 1'b1, 64'h08};
        vecs[8]  = '{1'b1, 1'b0, 64'h00, 1'b1, 64'h08};
        vecs[9]  = '{1'b0, 1'b0, 64'h00, 1'b1, 64'h0C};
        vecs[10] = '{1'b0, 1'b1, 64'h14, 1'b1, 64'h10};
        vecs[11] = '{1'b0, 1'b1, 64'h18, 1'b0, 64'h10};
        vecs[12] = '{1'b0, 1'b1, 64'h1C, 1'b1, 64'h14};

        reset = 1'b1; stall_if = 1'b0; flush_id = 1'b0; redirect_en = 1'b0;
        redirect_pc = 64'h0; inst_mem_ack = 1'b0; inst_mem_rd_dat = 32'h0;
        mem_busy = 1'b0; mem_rand = 1'b0; mem_lat = 1; mem_wait = 0; mem_addr = 64'h0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check("reset_rd_en", 64'(inst_mem_rd_en), 64'd0);
        check("reset_addr", inst_mem_addr, 64'h0);
        check("reset_inst", 64'(inst_id), 64'(NOP));
        check("reset_pc_id", pc_id, 64'h0);
        check("reset_valid", 64'(valid_id), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            stall_if = vecs[i].stall;
            cycle();
            exp_inst = vecs[i].exp_valid ? (vecs[i].exp_pc[31:0] ^ SALT) : NOP;
            check($sformatf("vec%0d_rd_en", i), 64'(inst_mem_rd_en), 64'(vecs[i].exp_rd));
            if (vecs[i].exp_rd) check($sformatf("vec%0d_addr", i), inst_mem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 64'(valid_id), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i), pc_id, vecs[i].exp_pc);
            check($sformatf("vec%0d_inst", i), 64'(inst_id), 64'(exp_inst));
        end
        stall_if = 1'b0;

        // Redirect while the request for 0x20 waits on a slow ack.
        mem_lat = 4;
        cycle();
        redirect_en = 1'b1;
        redirect_pc = 64'h100;
        cycle();
        redirect_en = 1'b0;
        check("drain_rd_en", 64'(inst_mem_rd_en), 64'd1);
        check("drain_addr", inst_mem_addr, 64'h20);
        check("drain_bubble", 64'(valid_id), 64'd0);
        n = 0;
        while (!inst_mem_ack && n < 10) begin cycle(); n++; end
        check("drain_ack_seen", 64'(inst_mem_ack), 64'd1);
        mem_lat = 1;
        cycle();
        check("redir_rd_en", 64'(inst_mem_rd_en), 64'd1);
        check("redir_addr", inst_mem_addr, 64'h100);
        check("redir_no_stale", 64'(valid_id), 64'd0);
        n = 0;
        while (!valid_id && n < 10) begin cycle(); n++; end
        check("redir_first_pc", pc_id, 64'h100);
        check("redir_first_inst", 64'(inst_id), 64'(32'h100 ^ SALT));

        // Flush wins over stall; pc_id keeps the last real PC.
        saved_pc = m_pc;
        stall_if = 1'b1;
        flush_id = 1'b1;
        cycle();
        check("flush_valid", 64'(valid_id), 64'd0);
        check("flush_inst", 64'(inst_id), 64'(NOP));
        check("flush_pc_hold", pc_id, saved_pc);
        stall_if = 1'b0;
        flush_id = 1'b0;

        // Misaligned redirect coincident with an ack.
        n = 0;
        while (!inst_mem_ack && n < 10) begin cycle(); n++; end
        check("coinc_ack_seen", 64'(inst_mem_ack), 64'd1);
        redirect_en = 1'b1;
        redirect_pc = 64'h203;
        cycle();
        redirect_en = 1'b0;
        check("misalign_rd_en", 64'(inst_mem_rd_en), 64'd1);
        check("misalign_addr", inst_mem_addr, 64'h200);
        n = 0;
        while (!valid_id && n < 10) begin cycle(); n++; end
        check("misalign_pc", pc_id, 64'h200);
        check("misalign_inst", 64'(inst_id), 64'(32'h200 ^ SALT));

        // Reset while a request is waiting for its ack.
        mem_lat = 5;
        n = 0;
        do begin cycle(); n++; end while (!(mem_busy && !inst_mem_ack) && n < 10);
        check("midreq_pending", 64'(inst_mem_rd_en), 64'd1);
        reset = 1'b1;
        #1;
        check("midreq_rst_rd_en", 64'(inst_mem_rd_en), 64'd0);
        check("midreq_rst_addr", inst_mem_addr, 64'h0);
        check("midreq_rst_valid", 64'(valid_id), 64'd0);
        check("midreq_rst_inst", 64'(inst_id), 64'(NOP));
        check("midreq_rst_pc", pc_id, 64'h0);
        model_reset();
        mem_busy = 1'b0;
        inst_mem_ack = 1'b0;
        mem_lat = 1;
        cycle();
        reset = 1'b0;
        cycle();
        check("midreq_first_rd_en", 64'(inst_mem_rd_en), 64'd1);
        check("midreq_first_addr", inst_mem_addr, 64'h0);

        // Randomized traffic, including redirects near the top of the address space.
        mem_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            stall_if    = ($urandom_range(0, 99) < 30);
            flush_id    = ($urandom_range(0, 99) < 8);
            redirect_en = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 9) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else
                redirect_pc = 64'($urandom_range(0, 65535));
            cycle();
        end
        stall_if = 1'b0;
        flush_id = 1'b0;
        redirect_en = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
